// File: rtl/mem_tile_pkg.sv
// Shared types, controller states and geometry helpers for the memory-tile bank controller.
// The typedefs describe the default bank geometry. Parameterised instances size their own signals.
package mem_tile_pkg;

  localparam int unsigned DefDataWidth = 256;
  localparam int unsigned DefNumWords  = 512;
  localparam int unsigned DefNumRows   = 4;

  typedef logic [$clog2(DefNumWords)-1:0]  sram_addr_t;
  typedef logic [DefDataWidth-1:0]         mem_data_t;
  typedef logic [DefDataWidth/8-1:0]       mem_be_t;
  typedef logic [$clog2(DefNumRows)-1:0]   macro_sel_t;

  typedef enum logic [1:0] {
    SBoot,
    SInit,
    SRun
  } ctrl_state_e;

  function automatic int unsigned word_addr_width(input int unsigned num_words);
    return $clog2(num_words);
  endfunction

  function automatic int unsigned macro_sel_width(input int unsigned num_rows);
    return $clog2(num_rows);
  endfunction

  // The macro select sits directly above the word-address field of the byte address.
  function automatic int unsigned macro_sel_offset(input int unsigned addr_offset,
                                                   input int unsigned num_words);
    return addr_offset + $clog2(num_words);
  endfunction

endpackage

// File: rtl/mem_tile_rsp_tracker.sv
// Fixed-depth shift register that carries per-request metadata to the cycle its response is due.
// Valid bits are cleared by the synchronous reset; the payload follows the valid bits unreset.
module mem_tile_rsp_tracker #(
  parameter int unsigned Depth = 1,
  parameter type payload_t = logic
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     in_valid_i,
  input  payload_t in_payload_i,
  output logic     out_valid_o,
  output payload_t out_payload_o
);

  logic [Depth-1:0] valid_q;
  payload_t         payload_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      for (int i = 1; i < Depth; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    payload_q[0] <= in_payload_i;
    for (int i = 1; i < Depth; i++) payload_q[i] <= payload_q[i-1];
  end

  assign out_valid_o   = valid_q[Depth-1];
  assign out_payload_o = payload_q[Depth-1];

endmodule

// File: rtl/mem_tile_bank_ctrl.sv
// Per-bank SRAM controller: zero-init sweep after reset, address decode onto a column of
// macros, optional request register, and fixed-latency response return.
module mem_tile_bank_ctrl
  import mem_tile_pkg::*;
#(
  parameter int unsigned SramDataWidth  = 256,
  parameter int unsigned SramNumWords   = 512,
  parameter int unsigned NumBankRows    = 4,
  parameter int unsigned AddrWidth      = 20,
  parameter int unsigned SramAddrOffset = 5,
  parameter int unsigned ReqPipe        = 0,
  parameter int unsigned SramLatency    = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   init_en_i,
  output logic                                   init_done_o,
  input  logic                                   mem_req_i,
  output logic                                   mem_gnt_o,
  input  logic [AddrWidth-1:0]                   mem_addr_i,
  input  logic                                   mem_we_i,
  input  logic [SramDataWidth-1:0]               mem_wdata_i,
  input  logic [SramDataWidth/8-1:0]             mem_be_i,
  output logic                                   mem_rvalid_o,
  output logic [SramDataWidth-1:0]               mem_rdata_o,
  output logic [NumBankRows-1:0]                 sram_req_o,
  output logic [NumBankRows-1:0]                 sram_we_o,
  output logic [$clog2(SramNumWords)-1:0]        sram_addr_o,
  output logic [SramDataWidth-1:0]               sram_wdata_o,
  output logic [SramDataWidth/8-1:0]             sram_be_o,
  input  logic [NumBankRows*SramDataWidth-1:0]   sram_rdata_i
);

  localparam int unsigned AW     = word_addr_width(SramNumWords);
  localparam int unsigned SelW   = macro_sel_width(NumBankRows);
  localparam int unsigned SelWE  = (SelW > 0) ? SelW : 1;
  localparam int unsigned SelOff = macro_sel_offset(SramAddrOffset, SramNumWords);
  localparam int unsigned CntW   = AW + SelW;
  localparam int unsigned BeW    = SramDataWidth / 8;
  localparam int unsigned Lat    = ReqPipe + SramLatency;
  localparam logic [CntW-1:0] CntMax = CntW'(NumBankRows * SramNumWords - 1);

  typedef struct packed {
    logic             is_read;
    logic [SelWE-1:0] sel;
  } trk_t;

  ctrl_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SBoot;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SBoot: state_d = init_en_i ? SInit : SRun;
      SInit: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntMax) begin
          state_d = SRun;
          cnt_d   = '0;
        end
      end
      SRun:    state_d = SRun;
      default: state_d = SBoot;
    endcase
  end

  // Handshake: a request transfers in a cycle with mem_req_i && mem_gnt_o; its response
  // (mem_rvalid_o) follows exactly Lat cycles later and cannot be back-pressured.
  assign run         = (state_q == SRun);
  assign init_done_o = run;
  assign mem_gnt_o   = run & mem_req_i;

  logic [SelWE-1:0] req_sel, init_sel;
  logic [AW-1:0]    req_word, init_word;
  logic             unused_addr;

  assign req_word    = mem_addr_i[SramAddrOffset +: AW];
  assign init_word   = cnt_q[AW-1:0];
  assign unused_addr = ^mem_addr_i;

  if (SelW > 0) begin : g_sel
    assign req_sel  = mem_addr_i[SelOff +: SelW];
    assign init_sel = cnt_q[AW +: SelW];
  end else begin : g_nosel
    assign req_sel  = '0;
    assign init_sel = '0;
  end

  logic                     st_v, st_we;
  logic [SelWE-1:0]         st_sel;
  logic [AW-1:0]            st_addr;
  logic [SramDataWidth-1:0] st_wdata;
  logic [BeW-1:0]           st_be;

  if (ReqPipe != 0) begin : g_pipe
    always_ff @(posedge clk_i) begin
      if (!rst_ni) st_v <= 1'b0;
      else         st_v <= mem_gnt_o;
    end
    always_ff @(posedge clk_i) begin
      st_we    <= mem_we_i;
      st_sel   <= req_sel;
      st_addr  <= req_word;
      st_wdata <= mem_wdata_i;
      st_be    <= mem_be_i;
    end
  end else begin : g_comb
    assign st_v     = mem_gnt_o;
    assign st_we    = mem_we_i;
    assign st_sel   = req_sel;
    assign st_addr  = req_word;
    assign st_wdata = mem_wdata_i;
    assign st_be    = mem_be_i;
  end

  // The sweep owns the macros while it runs; traffic cannot be in flight then.
  always_comb begin
    sram_req_o   = '0;
    sram_we_o    = '0;
    sram_addr_o  = st_addr;
    sram_wdata_o = st_wdata;
    sram_be_o    = st_be;
    if (state_q == SInit) begin
      sram_req_o[init_sel] = 1'b1;
      sram_we_o[init_sel]  = 1'b1;
      sram_addr_o          = init_word;
      sram_wdata_o         = '0;
      sram_be_o            = '1;
    end else if (st_v) begin
      sram_req_o[st_sel] = 1'b1;
      sram_we_o[st_sel]  = st_we;
    end
  end

  trk_t trk_in, trk_out;
  logic trk_v;

  assign trk_in.is_read = ~mem_we_i;
  assign trk_in.sel     = req_sel;

  mem_tile_rsp_tracker #(
    .Depth     (Lat),
    .payload_t (trk_t)
  ) u_tracker (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .in_valid_i    (mem_gnt_o),
    .in_payload_i  (trk_in),
    .out_valid_o   (trk_v),
    .out_payload_o (trk_out)
  );

  logic [SramDataWidth-1:0] rdata_arr [NumBankRows];

  for (genvar g = 0; g < NumBankRows; g++) begin : g_rdata
    assign rdata_arr[g] = sram_rdata_i[g*SramDataWidth +: SramDataWidth];
  end

  assign mem_rvalid_o = trk_v;
  assign mem_rdata_o  = (trk_v && trk_out.is_read) ? rdata_arr[trk_out.sel] : '0;

endmodule

// File: tb/tb_mem_tile_bank_ctrl.sv
// Directed bench for mem_tile_bank_ctrl: two instances (unpipelined 2-row, pipelined 4-row)
// share one request stream, each backed by a behavioural SRAM column.
module tb_mem_tile_bank_ctrl;

  localparam int DW  = 64;
  localparam int BW  = 8;
  localparam int NW  = 8;
  localparam int AW  = 12;
  localparam int OFF = 3;
  localparam int RA  = 2;
  localparam int RB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, init_en, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;

  logic             done_a, gnt_a, rvalid_a;
  logic [DW-1:0]    rdata_a, swdata_a;
  logic [RA-1:0]    sreq_a, swe_a;
  logic [2:0]       saddr_a;
  logic [BW-1:0]    sbe_a;
  logic [RA*DW-1:0] srdata_a;

  logic             done_b, gnt_b, rvalid_b;
  logic [DW-1:0]    rdata_b, swdata_b;
  logic [RB-1:0]    sreq_b, swe_b;
  logic [2:0]       saddr_b;
  logic [BW-1:0]    sbe_b;
  logic [RB*DW-1:0] srdata_b;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  logic cnt_clr, fill;
  logic [DW-1:0] mem_a [RA][NW];
  logic [DW-1:0] rd_a [RA];
  logic [DW-1:0] mem_b [RB][NW];
  logic [DW-1:0] rd_b0 [RB];
  logic [DW-1:0] rd_b1 [RB];
  int wr_cnt_a, wr_cnt_b, multi_a, multi_b;
  logic first_seen_a, first_seen_b;
  logic [RA-1:0] first_req_a;
  logic [RB-1:0] first_req_b;
  logic [2:0] first_addr_a, first_addr_b;

  mem_tile_bank_ctrl #(
    .SramDataWidth(DW), .SramNumWords(NW), .NumBankRows(RA), .AddrWidth(AW),
    .SramAddrOffset(OFF), .ReqPipe(0), .SramLatency(1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .init_en_i(init_en), .init_done_o(done_a),
    .mem_req_i(mem_req), .mem_gnt_o(gnt_a), .mem_addr_i(mem_addr), .mem_we_i(mem_we),
    .mem_wdata_i(mem_wdata), .mem_be_i(mem_be), .mem_rvalid_o(rvalid_a), .mem_rdata_o(rdata_a),
    .sram_req_o(sreq_a), .sram_we_o(swe_a), .sram_addr_o(saddr_a), .sram_wdata_o(swdata_a),
    .sram_be_o(sbe_a), .sram_rdata_i(srdata_a)
  );

  mem_tile_bank_ctrl #(
    .SramDataWidth(DW), .SramNumWords(NW), .NumBankRows(RB), .AddrWidth(AW),
    .SramAddrOffset(OFF), .ReqPipe(1), .SramLatency(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .init_en_i(init_en), .init_done_o(done_b),
    .mem_req_i(mem_req), .mem_gnt_o(gnt_b), .mem_addr_i(mem_addr), .mem_we_i(mem_we),
    .mem_wdata_i(mem_wdata), .mem_be_i(mem_be), .mem_rvalid_o(rvalid_b), .mem_rdata_o(rdata_b),
    .sram_req_o(sreq_b), .sram_we_o(swe_b), .sram_addr_o(saddr_b), .sram_wdata_o(swdata_b),
    .sram_be_o(sbe_b), .sram_rdata_i(srdata_b)
  );

  // Behavioural macros: latency 1 for column A, latency 2 for column B.
  always @(posedge clk) begin
    for (int i = 0; i < RA; i++) begin
      if (fill) begin
        for (int w = 0; w < NW; w++) mem_a[i][w] <= 64'hDEAD_BEEF_0000_0000 | 64'(i*NW + w + 1);
      end else if (sreq_a[i]) begin
        if (swe_a[i]) begin
          for (int j = 0; j < BW; j++) if (sbe_a[j]) mem_a[i][saddr_a][j*8 +: 8] <= swdata_a[j*8 +: 8];
        end else rd_a[i] <= mem_a[i][saddr_a];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < RB; i++) begin
      rd_b1[i] <= rd_b0[i];
      if (fill) begin
        for (int w = 0; w < NW; w++) mem_b[i][w] <= 64'hCAFE_F00D_0000_0000 | 64'(i*NW + w + 1);
      end else if (sreq_b[i]) begin
        if (swe_b[i]) begin
          for (int j = 0; j < BW; j++) if (sbe_b[j]) mem_b[i][saddr_b][j*8 +: 8] <= swdata_b[j*8 +: 8];
        end else rd_b0[i] <= mem_b[i][saddr_b];
      end
    end
  end

  for (genvar g = 0; g < RA; g++) begin : g_pack_a
    assign srdata_a[g*DW +: DW] = rd_a[g];
  end
  for (genvar g = 0; g < RB; g++) begin : g_pack_b
    assign srdata_b[g*DW +: DW] = rd_b1[g];
  end

  always @(posedge clk) begin
    if (cnt_clr) begin
      wr_cnt_a <= 0; wr_cnt_b <= 0; multi_a <= 0; multi_b <= 0;
      first_seen_a <= 1'b0; first_seen_b <= 1'b0;
      first_req_a <= '0; first_req_b <= '0; first_addr_a <= '0; first_addr_b <= '0;
    end else begin
      wr_cnt_a <= wr_cnt_a + $countones(sreq_a & swe_a);
      wr_cnt_b <= wr_cnt_b + $countones(sreq_b & swe_b);
      if ($countones(sreq_a) > 1) multi_a <= multi_a + 1;
      if ($countones(sreq_b) > 1) multi_b <= multi_b + 1;
      if (!first_seen_a && |(sreq_a & swe_a)) begin
        first_seen_a <= 1'b1; first_req_a <= sreq_a; first_addr_a <= saddr_a;
      end
      if (!first_seen_b && |(sreq_b & swe_b)) begin
        first_seen_b <= 1'b1; first_req_b <= sreq_b; first_addr_b <= saddr_b;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; init_en = 1'b1; cnt_clr = 1'b1; fill = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({done_a, gnt_a, rvalid_a} !== 3'b000) begin
      errors++; $display("FAIL reset_flags_a: got %b want 000", {done_a, gnt_a, rvalid_a}); end
    checks++; if ({sreq_a, swe_a} !== '0) begin
      errors++; $display("FAIL reset_sram_a: got %b want 0", {sreq_a, swe_a}); end
    checks++; if ({done_b, gnt_b, rvalid_b} !== 3'b000) begin
      errors++; $display("FAIL reset_flags_b: got %b want 000", {done_b, gnt_b, rvalid_b}); end
    checks++; if ({sreq_b, swe_b} !== '0) begin
      errors++; $display("FAIL reset_sram_b: got %b want 0", {sreq_b, swe_b}); end
  endtask

  task automatic test_init_sweep();
    int first_a = -1;
    int first_b = -1;
    int gnt_early = 0;
    int nz_a = 0;
    int nz_b = 0;
    logic gf_a = 1'b0;
    logic gf_b = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; cnt_clr = 1'b0; fill = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((gnt_a && !done_a) || (gnt_b && !done_b)) gnt_early++;
      if (done_a && first_a < 0) begin first_a = k; gf_a = gnt_a; end
      if (done_b && first_b < 0) begin first_b = k; gf_b = gnt_b; end
      @(posedge clk); #1;
    end
    mem_req = 1'b0;
    for (int i = 0; i < RA; i++) for (int w = 0; w < NW; w++) if (mem_a[i][w] !== '0) nz_a++;
    for (int i = 0; i < RB; i++) for (int w = 0; w < NW; w++) if (mem_b[i][w] !== '0) nz_b++;
    checks++; if (first_a != 17) begin errors++; $display("FAIL sweep_done_a: got cycle %0d want 17", first_a); end
    checks++; if (first_b != 33) begin errors++; $display("FAIL sweep_done_b: got cycle %0d want 33", first_b); end
    checks++; if (gnt_early != 0) begin errors++; $display("FAIL sweep_gnt_early: got %0d want 0", gnt_early); end
    checks++; if (gf_a !== 1'b1) begin errors++; $display("FAIL sweep_first_gnt_a: got %b want 1", gf_a); end
    checks++; if (gf_b !== 1'b1) begin errors++; $display("FAIL sweep_first_gnt_b: got %b want 1", gf_b); end
    checks++; if (wr_cnt_a != 16) begin errors++; $display("FAIL sweep_writes_a: got %0d want 16", wr_cnt_a); end
    checks++; if (wr_cnt_b != 32) begin errors++; $display("FAIL sweep_writes_b: got %0d want 32", wr_cnt_b); end
    checks++; if (multi_a + multi_b != 0) begin
      errors++; $display("FAIL sweep_onehot: got %0d multi-select cycles want 0", multi_a + multi_b); end
    checks++; if (nz_a != 0) begin errors++; $display("FAIL sweep_zero_a: got %0d nonzero words want 0", nz_a); end
    checks++; if (nz_b != 0) begin errors++; $display("FAIL sweep_zero_b: got %0d nonzero words want 0", nz_b); end
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic test_skip_init();
    init_en = 1'b0; rst_n = 1'b0; cnt_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; cnt_clr = 1'b0;
    @(negedge clk);
    checks++; if ({done_a, done_b} !== 2'b00) begin
      errors++; $display("FAIL skip_boot_done: got %b want 00", {done_a, done_b}); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({done_a, done_b} !== 2'b11) begin
      errors++; $display("FAIL skip_done: got %b want 11", {done_a, done_b}); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_cnt_a != 0) begin errors++; $display("FAIL skip_writes_a: got %0d want 0", wr_cnt_a); end
    checks++; if (wr_cnt_b != 0) begin errors++; $display("FAIL skip_writes_b: got %0d want 0", wr_cnt_b); end
  endtask

  task automatic test_back_to_back();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'h058; mem_wdata = {8{8'hA5}}; mem_be = 8'hFF;
    @(negedge clk);
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL b2b_gnt_wr: got %b want 1", gnt_a); end
    checks++; if ({sreq_a, swe_a, saddr_a} !== {2'b10, 2'b10, 3'd3}) begin
      errors++; $display("FAIL b2b_sram_wr: got %b want 10_10_011", {sreq_a, swe_a, saddr_a}); end
    @(posedge clk); #1;
    mem_we = 1'b0; mem_addr = 12'h05F;
    @(negedge clk);
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL b2b_gnt_rd1: got %b want 1", gnt_a); end
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== '0) begin
      errors++; $display("FAIL b2b_wr_rsp: got v=%b d=%h want v=1 d=0", rvalid_a, rdata_a); end
    @(posedge clk); #1;
    mem_addr = 12'h818;
    @(negedge clk);
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL b2b_gnt_rd2: got %b want 1", gnt_a); end
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== {8{8'hA5}}) begin
      errors++; $display("FAIL b2b_rd1_rsp: got v=%b d=%h want v=1 d=%h", rvalid_a, rdata_a, {8{8'hA5}}); end
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== '0) begin
      errors++; $display("FAIL b2b_rd2_rsp: got v=%b d=%h want v=1 d=0", rvalid_a, rdata_a); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", rvalid_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_write();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'h020; mem_wdata = '1; mem_be = 8'h0F;
    @(negedge clk);
    checks++; if ({sreq_a, sbe_a} !== {2'b01, 8'h0F}) begin
      errors++; $display("FAIL pw_sram: got %b want 01_00001111", {sreq_a, sbe_a}); end
    @(posedge clk); #1;
    mem_we = 1'b0; mem_be = 8'hFF;
    @(negedge clk);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== '0) begin
      errors++; $display("FAIL pw_wr_rsp: got v=%b d=%h want v=1 d=0", rvalid_a, rdata_a); end
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 64'h0000_0000_FFFF_FFFF) begin
      errors++; $display("FAIL pw_rd_rsp: got v=%b d=%h want v=1 d=00000000ffffffff", rvalid_a, rdata_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_pipelined();
    int order [4] = '{2, 0, 3, 1};
    logic [DW-1:0] exp;
    for (int m = 0; m < 4; m++) begin
      mem_req = 1'b1; mem_we = 1'b1; mem_be = 8'hFF;
      mem_addr = 12'((m << 6) | 'h28);
      mem_wdata = 64'h1111_1111_1111_1111 * 64'(m + 1);
      @(posedge clk); #1;
    end
    mem_req = 1'b0; mem_we = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        mem_req = 1'b1;
        mem_addr = 12'((order[c] << 6) | 'h28);
        exp_q.push_back(64'h1111_1111_1111_1111 * 64'(order[c] + 1));
      end else mem_req = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        checks++; if (sreq_b !== 4'b0000) begin errors++; $display("FAIL pipe_sram_c0: got %b want 0000", sreq_b); end
      end
      if (c == 1) begin
        checks++; if ({sreq_b, swe_b} !== 8'b0100_0000) begin
          errors++; $display("FAIL pipe_sram_c1: got %b want 0100_0000", {sreq_b, swe_b}); end
      end
      if (c >= 3 && c <= 6) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (rvalid_b !== 1'b1 || rdata_b !== exp) begin
          errors++; $display("FAIL pipe_rsp_%0d: got v=%b d=%h want v=1 d=%h", c, rvalid_b, rdata_b, exp); end
      end else begin
        checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL pipe_idle_%0d: got %b want 0", c, rvalid_b); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    int first_b = -1;
    int stale = 0;
    init_en = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h068;
    @(negedge clk); @(posedge clk); #1;
    mem_addr = 12'h0E8;
    @(negedge clk); @(posedge clk); #1;
    mem_req = 1'b0; rst_n = 1'b0; cnt_clr = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({rvalid_b, done_b} !== 2'b00) begin
      errors++; $display("FAIL rst_flush_b: got %b want 00", {rvalid_b, done_b}); end
    checks++; if ({rvalid_a, done_a} !== 2'b00) begin
      errors++; $display("FAIL rst_flush_a: got %b want 00", {rvalid_a, done_a}); end
    @(posedge clk); #1;
    rst_n = 1'b1; cnt_clr = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rvalid_a || rvalid_b) stale++;
      if (done_b && first_b < 0) first_b = k;
      @(posedge clk); #1;
    end
    checks++; if (first_b != 33) begin errors++; $display("FAIL rst_resweep_done_b: got cycle %0d want 33", first_b); end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale_rsp: got %0d want 0", stale); end
    checks++; if ({first_req_b, first_addr_b} !== {4'b0001, 3'd0}) begin
      errors++; $display("FAIL rst_first_wr_b: got %b want 0001_000", {first_req_b, first_addr_b}); end
    checks++; if ({first_req_a, first_addr_a} !== {2'b01, 3'd0}) begin
      errors++; $display("FAIL rst_first_wr_a: got %b want 01_000", {first_req_a, first_addr_a}); end
    checks++; if (wr_cnt_b != 32) begin errors++; $display("FAIL rst_resweep_writes_b: got %0d want 32", wr_cnt_b); end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_skip_init();
    test_back_to_back();
    test_partial_write();
    test_pipelined();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
